// File: rtl/sample_scheduler.sv
// sample_scheduler: base-tick prescaler, per-channel period counters and a
// round-robin req/ack arbiter that grants one expired channel at a time.
// Build option: define SCHED_OVERRUN_EN to implement sticky per-channel
// overrun detection; otherwise overrun is tied to 0.

module sample_scheduler #(
  parameter int unsigned CLKFREQ  = 100_000_000,
  parameter int unsigned TICKFREQ = 100,
  parameter int unsigned NCH      = 4,
  parameter int unsigned PW       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [PW-1:0]           cfg_period,
  input  logic                    sample_ack,
  output logic                    tick,
  output logic [NCH-1:0]          sample_req,
  output logic [$clog2(NCH)-1:0]  sample_id,
  output logic                    busy,
  output logic [NCH-1:0]          overrun
);

  localparam int unsigned TICKDIV = CLKFREQ / TICKFREQ;
  localparam int unsigned QW      = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
  localparam int unsigned IW      = $clog2(NCH);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e          state;
  logic [QW-1:0]   q;
  logic [IW-1:0]   ptr;
  logic [PW-1:0]   period [NCH];
  logic [PW-1:0]   cnt    [NCH];
  logic [NCH-1:0]  pending;
  logic [NCH-1:0]  expire;
  logic [NCH-1:0]  ack_clr;
  logic [NCH-1:0]  cfg_hit;
  logic            sel_found;
  logic [IW-1:0]   sel_id;

  // Prescaler: tick is registered, high the cycle after q reaches TICKDIV-1
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (q == QW'(TICKDIV - 1));
      q    <= (q == QW'(TICKDIV - 1)) ? '0 : q + QW'(1);
    end
  end

  // Per-channel decode of config hits, expiries and ack clears
  always_comb begin
    cfg_hit = '0;
    expire  = '0;
    ack_clr = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      // an out-of-range cfg_ch matches no channel and is dropped
      cfg_hit[i] = cfg_we && (cfg_ch == IW'(i));
      expire[i]  = tick && (period[i] != '0) && (cnt[i] == PW'(1));
      ack_clr[i] = (state == StReq) && sample_ack && (sample_id == IW'(i));
    end
  end

  // Channel countdown and pending flags; a config write overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NCH); i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
      pending <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (cfg_hit[i]) begin
          period[i]  <= cfg_period;
          cnt[i]     <= cfg_period;
          pending[i] <= 1'b0;
        end else begin
          if (tick && (period[i] != '0)) begin
            cnt[i] <= (cnt[i] == PW'(1)) ? period[i] : cnt[i] - PW'(1);
          end
          // expiry coinciding with an ack keeps the channel pending
          pending[i] <= expire[i] | (pending[i] & ~ack_clr[i]);
        end
      end
    end
  end

`ifdef SCHED_OVERRUN_EN
  // Sticky overrun: expiry on a channel still pending and not being acked
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (cfg_hit[i]) begin
          overrun[i] <= 1'b0;
        end else if (expire[i] && pending[i] && !ack_clr[i]) begin
          overrun[i] <= 1'b1;
        end
      end
    end
  end
`else
  assign overrun = '0;
`endif

  // Round-robin pick: first pending channel after ptr, wrapping
  always_comb begin
    int unsigned idx;
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int off = 1; off <= int'(NCH); off++) begin
      idx = (int'(ptr) + off) % NCH;
      if (!sel_found && pending[idx]) begin
        sel_found = 1'b1;
        sel_id    = IW'(idx);
      end
    end
  end

  // Grant FSM with registered request, id and busy outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      ptr        <= IW'(NCH - 1);
      sample_req <= '0;
      sample_id  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (sel_found) begin
            sample_req <= {{(NCH-1){1'b0}}, 1'b1} << sel_id;
            sample_id  <= sel_id;
            busy       <= 1'b1;
            state      <= StReq;
          end
        end
        StReq: begin
          if (sample_ack) begin
            ptr        <= sample_id;
            sample_req <= '0;
            busy       <= 1'b0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_scheduler.sv
// Directed bench for sample_scheduler (CLKFREQ=1000, TICKFREQ=100 -> TICKDIV=10).
module tb_sample_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_period;
  logic       sample_ack;
  logic       tick;
  logic [3:0] sample_req;
  logic [1:0] sample_id;
  logic       busy;
  logic [3:0] overrun;

  sample_scheduler #(
    .CLKFREQ  (1000),
    .TICKFREQ (100),
    .NCH      (4),
    .PW       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .sample_ack (sample_ack),
    .tick       (tick),
    .sample_req (sample_req),
    .sample_id  (sample_id),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // grant log: one entry per rising edge of sample_req
  int         g_id   [$];
  logic [3:0] g_req  [$];
  int         g_cyc  [$];
  logic       g_tick2[$];

  logic       auto_ack = 1'b0;
  logic [3:0] prev_req = '0;
  logic       t1 = 1'b0;
  logic       t2 = 1'b0;
  int         cyc = 0;

`ifdef SCHED_OVERRUN_EN
  localparam logic [3:0] OvrExp = 4'b0010;
`else
  localparam logic [3:0] OvrExp = 4'b0000;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (sample_req != 4'b0 && prev_req == 4'b0) begin
      g_id.push_back(int'(sample_id));
      g_req.push_back(sample_req);
      g_cyc.push_back(cyc);
      g_tick2.push_back(t2);
    end
    prev_req = sample_req;
    t2 = t1;
    t1 = tick;
    if (auto_ack) sample_ack = (sample_req != 4'b0) && !sample_ack;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_log();
    g_id.delete();
    g_req.delete();
    g_cyc.delete();
    g_tick2.delete();
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] p);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_period = p;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    sample_ack = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int max);
    int k = 0;
    while (sample_req == 4'b0 && k < max) begin
      step();
      k++;
    end
    check(tag, sample_req != 4'b0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nt, last, bad, rs, os, n0, n2;
    reset = 1'b1;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_period = '0;
    sample_ack = 1'b0;

    // reset values
    do_reset();
    check("rst_tick", tick, 0);
    check("rst_req", sample_req, 0);
    check("rst_id", sample_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);

    // unconfigured: tick every 10 cycles, no requests
    nt = 0; last = -1; bad = 0; rs = 0; os = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tick) begin
        if (last >= 0 && cyc - last != 10) bad++;
        last = cyc;
        nt++;
      end
      if (sample_req != 4'b0 || busy) rs = 1;
      if (overrun != 4'b0) os = 1;
    end
    check("idle_ticks", nt, 20);
    check("idle_gap", bad, 0);
    check("idle_req", rs, 0);
    check("idle_ovr", os, 0);

    // single channel, period 2, prompt ack
    auto_ack = 1'b1;
    clear_log();
    cfg(2'd0, 8'd2);
    run(70);
    check("single_cnt", g_id.size() >= 3, 1);
    for (int j = 0; j < g_id.size(); j++) begin
      check("single_id", g_id[j], 0);
      check("single_req", g_req[j], 4'b0001);
      check("single_tick2", g_tick2[j], 1);
      if (j > 0) check("single_gap", g_cyc[j] - g_cyc[j-1], 20);
    end

    // round-robin over four period-1 channels
    do_reset();
    clear_log();
    for (int c = 0; c < 4; c++) cfg(2'(c), 8'd1);
    run(100);
    check("rr_cnt", g_id.size() >= 12, 1);
    for (int j = 0; j < 12 && j < g_id.size(); j++) begin
      check("rr_id", g_id[j], j % 4);
      check("rr_req", g_req[j], 32'(1) << (j % 4));
    end

    // overrun with ack withheld
    do_reset();
    auto_ack = 1'b0;
    cfg(2'd1, 8'd1);
    run(25);
    check("ovr_flag", overrun, OvrExp);
    check("ovr_req", sample_req, 4'b0010);
    check("ovr_id", sample_id, 1);
    check("ovr_busy", busy, 1);
    cfg(2'd1, 8'd1);
    check("ovr_clr", overrun, 0);
    check("ovr_req_kept", sample_req, 4'b0010);
    sample_ack = 1'b1;
    step();
    sample_ack = 1'b0;
    check("ovr_ack_req", sample_req, 0);
    check("ovr_ack_busy", busy, 0);

    // disable a pending channel while another is granted
    do_reset();
    auto_ack = 1'b0;
    cfg(2'd0, 8'd1);
    cfg(2'd2, 8'd1);
    wait_req("dis_wait", 40);
    check("dis_first", sample_req, 4'b0001);
    cfg(2'd2, 8'd0);
    auto_ack = 1'b1;
    clear_log();
    run(60);
    n0 = 0; n2 = 0;
    for (int j = 0; j < g_id.size(); j++) begin
      if (g_id[j] == 0) n0++;
      if (g_id[j] == 2) n2++;
    end
    check("dis_ch2", n2, 0);
    check("dis_ch0", n0 >= 3, 1);

    // reset mid-REQ with ack held
    do_reset();
    auto_ack = 1'b0;
    cfg(2'd3, 8'd1);
    wait_req("mid_wait", 40);
    check("mid_req_pre", sample_req, 4'b1000);
    check("mid_id_pre", sample_id, 3);
    sample_ack = 1'b1;
    reset = 1'b1;
    step();
    check("mid_req", sample_req, 0);
    check("mid_busy", busy, 0);
    check("mid_id", sample_id, 0);
    check("mid_tick", tick, 0);
    reset = 1'b0;
    clear_log();
    run(50);
    check("mid_nogrant", g_id.size(), 0);
    check("mid_end_req", sample_req, 0);
    sample_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_scheduler.md
# sample_scheduler

Timebase and arbiter for sensor sampling in the health monitor. It divides the system clock into a base tick and runs a programmable per-channel period counter for each sensor channel. Expired channels are granted one at a time, in round-robin order, through a req/ack handshake. Sensor front-ends receive single-cycle enables and requests, not derived clocks, so the whole datapath stays on `clk`.

## Interface
- `CLKFREQ`, 100_000_000, system clock frequency in Hz
- `TICKFREQ`, 100, base tick rate in Hz; `TICKDIV = CLKFREQ/TICKFREQ`, must be ≥ 2
- `NCH`, 4, number of sensor channels, ≥ 2
- `PW`, 8, period register width, in base ticks
- `clk`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `cfg_we`  in  1  config write strobe, one cycle
- `cfg_ch`  in  $clog2(NCH)  channel addressed by the write
- `cfg_period`  in  PW  period in ticks; 0 disables the channel
- `sample_ack`  in  1  requester accepted the current grant
- `tick`  out  1  one-cycle base tick pulse
- `sample_req`  out  NCH  one-hot request, held until ack
- `sample_id`  out  $clog2(NCH)  binary index of the granted channel
- `busy`  out  1  high while in REQ
- `overrun`  out  NCH  sticky per-channel overrun flags

## Operation
- **Prescaler:** `q` counts 0..TICKDIV-1 and wraps. `tick` is registered and high for the one cycle after `q == TICKDIV-1`.
- **Per-channel state:** `period[i]`, down-counter `cnt[i]` (PW bits), `pending[i]`.
- **Channel countdown:** on `tick` with `period[i] != 0`:
  - if `cnt[i] == 1`: expire, and reload `cnt[i] <= period[i]`;
  - else `cnt[i] <= cnt[i] - 1`.
  - Period 1 expires on every tick. Expiry sets `pending[i]`.
- **Config write:** `cfg_we` loads `period[cfg_ch]` and `cnt[cfg_ch]` with `cfg_period`, and clears `pending[cfg_ch]` and `overrun[cfg_ch]`. An out-of-range `cfg_ch` (≥ NCH) is ignored.
- **FSM states:** IDLE and REQ.
  - **IDLE:** if any `pending` is set, select the first set bit searching from `ptr+1` with wrap. Load the `sample_req` one-hot and `sample_id`, then go to REQ.
  - **REQ:** hold `sample_req`/`sample_id` stable. When `sample_ack` is high, clear `pending[id]`, set `ptr <= id`, drive `sample_req` to 0, and return to IDLE.
  - `sample_ack` outside REQ is ignored.
- **Overrun:** set when channel `i` expires while `pending[i]` is already set and is not being cleared by an ack in the same cycle.
- **Simultaneous events, same channel, same cycle:**
  - Expiry and ack: `pending` stays set; no overrun.
  - Expiry and config write: the write wins.
  - Config write during REQ for the granted channel: the active request is not aborted; `pending` is cleared and the transaction completes on ack.
- **Reset values:** `tick`, `sample_req`, `sample_id`, `busy` and `overrun` all 0. `q`, all `cnt` and all `period` are 0, so every channel is disabled. `pending` is 0, FSM is in IDLE, and `ptr = NCH-1`, so channel 0 has first priority.

## Timing
- **Tick to request:** `tick` high in cycle k → `pending` set at edge k+1 → FSM in REQ and `sample_req` high from cycle k+2.
- **Ack to release:** ack high in cycle m → `sample_req` low from cycle m+1.
- **Grant spacing:** at least one IDLE cycle separates consecutive grants, so peak throughput is one grant per two cycles.
- **Reset mid-transaction:** `reset` in any cycle forces the reset values on the next edge, including mid-REQ. A held `sample_ack` after reset is ignored.

## Configuration
- **`SCHED_OVERRUN_EN`:**
  - Defined: overrun detection and the sticky `overrun` flags are implemented as described.
  - Undefined: no overrun logic is built; `overrun` is tied to 0 and an expiry on an already-pending channel is silently merged.

## Test plan
Bench parameters: `CLKFREQ=1000`, `TICKFREQ=100` (so `TICKDIV=10`), `NCH=4`, `PW=8`.
- **No configuration after reset:** `tick` pulses every 10 cycles; `sample_req` and `overrun` stay 0 for 200 cycles.
- **Single channel, prompt ack:** write ch0 period 2 and ack 1 cycle after each req → `sample_req=4'b0001`, `sample_id=0` every 20 cycles, each req starting 2 cycles after a `tick`.
- **Round-robin:** all four channels period 1, ack 1 cycle after each req → grant order 0,1,2,3,0,… with no channel skipped or repeated.
- **Overrun:** ch1 period 1, ack withheld for 25 cycles → `overrun[1]=1` after the second expiry with the macro defined, stays 0 without it; a ch1 config write clears the flag.
- **Disable while pending:** ch2 pending, then write ch2 period 0 while ch2 is not granted → ch2 is never granted; other channels are unaffected.
- **Reset mid-REQ:** `reset` during REQ with `sample_ack` held → next cycle `sample_req=0`, `busy=0`; no grants until channels are rewritten.
